// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-address generator.
package pc_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} pc_state_e;
  typedef enum logic [2:0] {SEL_EXC, SEL_ERET, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ} next_sel_e;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; pushing when full overwrites the oldest entry.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
  logic [PW-1:0] ptr_q, ptr_d, top_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    // pop-then-push collapses to rewriting the top slot in place
    if (do_pop && push) begin
      mem_d[top_idx] = push_data;
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch-address generator: next-PC select, boot/run/halt control and RAS prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_valid,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] epc,
  input  logic              call_push,
  input  logic              ret_pop,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              pc_valid,
  output logic              ras_hit,
  output logic              misalign,
  output logic [1:0]        state_o
);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] RST_PC   = RESET_VEC & ~LOW_MASK;
  localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VEC & ~LOW_MASK;

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ras_hit_q, ras_hit_d;
  logic              misalign_q, misalign_d;
  next_sel_e         sel;
  logic              flush, advance, ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;

  assign pc_plus = pc_q + ADDR_W'(INST_BYTES);

  always_comb begin
    sel = SEL_SEQ;
    if (exc_valid)                  sel = SEL_EXC;
    else if (eret_valid)            sel = SEL_ERET;
    else if (redirect_valid)        sel = SEL_REDIR;
    else if (hold)                  sel = SEL_HOLD;
    else if (ret_pop && !ras_empty) sel = SEL_RAS;
  end

  // halt_req in RUN beats hold/RAS/sequential, so the stack is left untouched on that edge
  assign flush    = (sel == SEL_EXC) || (sel == SEL_ERET) || (sel == SEL_REDIR);
  assign advance  = (state_q == RUN) && !halt_req && ((sel == SEL_RAS) || (sel == SEL_SEQ));
  assign ras_push = advance & call_push;
  assign ras_pop  = advance & ret_pop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ras_hit_d  = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!flush && halt_req) begin
          state_d = HALTED;
        end else begin
          unique case (sel)
            SEL_EXC:   pc_d = EXC_PC;
            SEL_ERET: begin
              pc_d       = epc & ~LOW_MASK;
              misalign_d = |(epc & LOW_MASK);
            end
            SEL_REDIR: begin
              pc_d       = redirect_target & ~LOW_MASK;
              misalign_d = |(redirect_target & LOW_MASK);
            end
            SEL_HOLD:  pc_d = pc_q;
            SEL_RAS: begin
              pc_d      = ras_top & ~LOW_MASK;
              ras_hit_d = 1'b1;
            end
            default:   pc_d = pc_plus;
          endcase
        end
      end
      HALTED: begin
        if (exc_valid) begin
          pc_d    = EXC_PC;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RST_PC;
      ras_hit_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ras_hit_q  <= ras_hit_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(.RAS_DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc       = pc_q;
  assign pc_valid = (state_q == RUN);
  assign ras_hit  = ras_hit_q;
  assign misalign = misalign_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit; state advances on the falling edge, sampled on the rising edge.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        hold, redirect_valid, exc_valid, eret_valid, call_push, ret_pop, halt_req, resume;
  logic [31:0] redirect_target, epc;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, ras_hit, misalign;
  logic [1:0]  state_o;

  int checks = 0;
  int failures = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
    .call_push(call_push), .ret_pop(ret_pop),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
    .ras_hit(ras_hit), .misalign(misalign), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one active (falling) edge, then return at the following rising edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic jump(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; hold = 0; redirect_valid = 0; exc_valid = 0; eret_valid = 0;
    call_push = 0; ret_pop = 0; halt_req = 0; resume = 0;
    redirect_target = '0; epc = '0;
    tick(); tick();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_hit", 32'(ras_hit), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);

    // boot sequence
    reset = 1'b1;
    chk("boot_valid", 32'(pc_valid), 32'd0);
    tick();
    chk("run0_pc", pc, 32'h3000);
    chk("run0_valid", 32'(pc_valid), 32'd1);
    chk("run0_state", 32'(state_o), 32'd1);
    tick(); chk("seq1_pc", pc, 32'h3004);
    tick(); chk("seq2_pc", pc, 32'h3008);
    chk("pc_plus", pc_plus, 32'h300c);

    // hold with redirect override
    jump(32'h3010); chk("jmp_pc", pc, 32'h3010);
    hold = 1'b1;
    tick(); chk("hold1_pc", pc, 32'h3010);
    redirect_valid = 1'b1; redirect_target = 32'h3400;
    tick(); chk("hold_redir_pc", pc, 32'h3400);
    redirect_valid = 1'b0;
    tick(); chk("hold3_pc", pc, 32'h3400);
    hold = 1'b0;

    // priority and eret alignment
    exc_valid = 1; eret_valid = 1; redirect_valid = 1; epc = 32'h3022; redirect_target = 32'h3500;
    tick(); chk("prio_pc", pc, 32'h4180); chk("prio_mis", 32'(misalign), 32'd0);
    exc_valid = 0; redirect_valid = 0;
    tick(); chk("eret_pc", pc, 32'h3020); chk("eret_mis", 32'(misalign), 32'd1);
    eret_valid = 0;
    tick(); chk("post_eret_pc", pc, 32'h3024); chk("mis_pulse", 32'(misalign), 32'd0);

    // RAS overflow: 5 calls into a 4-deep stack
    for (int k = 0; k < 5; k++) begin
      jump(32'h3000 + 32'(k) * 32'h100);
      call_push = 1'b1;
      tick();
      call_push = 1'b0;
      chk("call_pc", pc, 32'h3004 + 32'(k) * 32'h100);
    end
    ret_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ret_pc", pc, 32'h3404 - 32'(k) * 32'h100);
      chk("ret_hit", 32'(ras_hit), 32'd1);
    end
    tick(); chk("ret_empty_pc", pc, 32'h3108); chk("ret_empty_hit", 32'(ras_hit), 32'd0);
    ret_pop = 1'b0;

    // halt / resume / exception wake
    jump(32'h3050);
    halt_req = 1'b1;
    tick(); chk("halt_pc", pc, 32'h3050); chk("halt_valid", 32'(pc_valid), 32'd0);
    chk("halt_state", 32'(state_o), 32'd2);
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3400;
    tick(); chk("halt_ign_pc", pc, 32'h3050); chk("halt_ign_state", 32'(state_o), 32'd2);
    redirect_valid = 1'b0; resume = 1'b1; halt_req = 1'b1;
    tick(); chk("resume_state", 32'(state_o), 32'd1); chk("resume_pc", pc, 32'h3050);
    chk("resume_valid", 32'(pc_valid), 32'd1);
    resume = 1'b0; halt_req = 1'b0;
    tick(); chk("resume_seq", pc, 32'h3054);
    halt_req = 1'b1;
    tick(); chk("halt2_state", 32'(state_o), 32'd2);
    halt_req = 1'b0; exc_valid = 1'b1;
    tick(); chk("halt_exc_pc", pc, 32'h4180); chk("halt_exc_state", 32'(state_o), 32'd1);
    exc_valid = 1'b0;
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3600;
    tick(); chk("halt_vs_redir_pc", pc, 32'h3600); chk("halt_vs_redir_st", 32'(state_o), 32'd1);
    halt_req = 1'b0; redirect_valid = 1'b0;

    // simultaneous pop and push replaces the top entry
    call_push = 1'b1;
    tick(); chk("push_pc", pc, 32'h3604);
    ret_pop = 1'b1;
    tick(); chk("popush_pc", pc, 32'h3604); chk("popush_hit", 32'(ras_hit), 32'd1);
    call_push = 1'b0;
    tick(); chk("replaced_pc", pc, 32'h3608); chk("replaced_hit", 32'(ras_hit), 32'd1);
    tick(); chk("empty_pc", pc, 32'h360c); chk("empty_hit", 32'(ras_hit), 32'd0);
    ret_pop = 1'b0;

    // address wrap
    jump(32'hFFFF_FFFC); chk("wrap_plus", pc_plus, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);

    // async reset while halted with a push pending
    jump(32'h3700);
    call_push = 1'b1;
    tick(); chk("pre_rst_pc", pc, 32'h3704);
    halt_req = 1'b1;
    tick(); chk("pre_rst_state", 32'(state_o), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h3000);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_valid", 32'(pc_valid), 32'd0);
    @(posedge clk);
    reset = 1'b1; call_push = 1'b0; halt_req = 1'b0;
    tick(); chk("post_rst_pc", pc, 32'h3000);
    ret_pop = 1'b1;
    tick(); chk("post_rst_pop_pc", pc, 32'h3004); chk("post_rst_pop_hit", 32'(ras_hit), 32'd0);
    ret_pop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch-address generator; successor to the single-register program counter.
- Sits at the head of IF and drives the fetch address to instruction memory.
- Each cycle selects the next PC from these sources: sequential, redirect from EX, exception vector, exception return, or return-address-stack (RAS) prediction.
- Has a boot/run/halt state machine and a circular RAS of configurable depth.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h0000_3000, first fetch address after reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- INST_BYTES, 4, sequential increment; power of two; low log2(INST_BYTES) bits of every PC are forced to 0.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; state updates on the falling edge, as in the existing pipeline.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  hazard stall; freezes sequential and predicted advance.
- redirect_valid  in  1  branch/jump resolved in EX.
- redirect_target  in  ADDR_W  redirect address.
- exc_valid  in  1  exception taken.
- eret_valid  in  1  return from exception.
- epc  in  ADDR_W  eret target.
- call_push  in  1  fetched instruction is a call; push pc+INST_BYTES.
- ret_pop  in  1  fetched instruction is a return; predict from RAS.
- halt_req  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- pc  out  ADDR_W  current fetch address.
- pc_plus  out  ADDR_W  pc+INST_BYTES, combinational.
- pc_valid  out  1  pc is a real fetch (0 in BOOT/HALTED).
- ras_hit  out  1  registered; last advance used a RAS prediction.
- misalign  out  1  registered one-cycle pulse; accepted target had nonzero low bits.
- state_o  out  2  debug: BOOT=0, RUN=1, HALTED=2.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VEC, state=BOOT, pc_valid=0, ras_hit=0, misalign=0, RAS count=0, RAS pointer=0.
- BOOT: lasts one falling edge after reset deasserts, then goes to RUN with pc=RESET_VEC and pc_valid=1. All other inputs are ignored in BOOT.
- RUN, next-pc priority per falling edge (highest first):
  1. exc_valid → EXC_VEC.
  2. eret_valid → epc.
  3. redirect_valid → redirect_target.
  4. hold → pc unchanged.
  5. ret_pop with RAS non-empty → top of RAS, and ras_hit=1.
  6. Otherwise → pc+INST_BYTES.
- Latency: the chosen target appears on pc after 1 falling edge (0 cycles of bubble inserted by this block).
- Items 1–3 override hold (flush semantics).
- RAS update: call_push and ret_pop act only when the outcome is item 5 or 6.
  - Pop happens before push, so simultaneous pop and push replaces the top entry.
  - Push when full overwrites the oldest entry: pointer wraps, count saturates at RAS_DEPTH.
  - Pop when empty: no change, falls through to sequential, ras_hit=0.
  - The RAS is not repaired on redirect or exception.
- Alignment: redirect_target and epc are masked to INST_BYTES alignment. misalign=1 for the cycle after an accepted target had any nonzero dropped bit.
- Arithmetic: pc+INST_BYTES wraps modulo 2^ADDR_W. No overflow flag.
- HALTED:
  - Entered from RUN on halt_req, only when no item 1–3 is active (those win and halt_req is dropped).
  - While HALTED: pc holds, pc_valid=0.
  - exc_valid → pc=EXC_VEC, state=RUN.
  - resume → state=RUN, pc unchanged.
  - All other inputs are ignored.
- Simultaneous halt_req and resume in HALTED: resume wins.
- Reset asserted at any time, including mid-HALTED or during a redirect, returns everything to reset values immediately.

Decomposition:
- Package pc_pkg holds:
  - enum pc_state_e {BOOT, RUN, HALTED};
  - enum next_sel_e {SEL_EXC, SEL_ERET, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ};
  - default vector constants.
- One sub-module: pc_ras. Circular stack with ports push, pop, push_data, top, empty, full. It is parametrised by RAS_DEPTH and ADDR_W and shares the same clock edge and reset.

Test Plan:
- Reset release, no other inputs: pc reads 3000 with pc_valid=0 for one cycle, then 3000 with pc_valid=1, then 3004, 3008 on successive falling edges.
- Hold for 3 edges at pc=3010 with redirect_valid=1 and target=3400 on the second edge: pc=3010, then 3400, then 3400 (held).
- exc_valid, eret_valid and redirect_valid all set together: next pc=4180. Next edge with eret_valid and epc=3022: pc=3020 and misalign=1 for one cycle.
- RAS: 5 calls from pcs 3000, 3100, 3200, 3300, 3400 with RAS_DEPTH=4. Then 5 returns: predicted 3404, 3304, 3204, 3104, then the 5th is sequential with ras_hit=0.
- halt_req at pc=3050: pc holds at 3050 with pc_valid=0. resume → 3050 then 3054. A second halt followed by exc_valid → pc=4180 in RUN.
- reset pulsed low mid-RAS-push while HALTED: pc=3000, state=BOOT, RAS empty; the first ret_pop afterwards gives ras_hit=0.
